apb_rr_master_arbiter: RTL

//  Shares one APB master port (the APB side behind ahb_to_apb_bridge) among NREQ local requesters.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/apb_rr_pick.sv | 32 +++
 rtl/apb_rr_master_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the round-robin APB master arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} arb_state_e;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int DEF_TIMEOUT = 16;

   // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT of 0 or 1.
   function automatic int tcnt_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module apb_rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant_oh,
   output logic [IW-1:0]   grant_idx,
   output logic            any
);

   logic          found;
   logic [IW-1:0] j;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any       = |req;
      found     = 1'b0;
      j         = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = IW'((int'(ptr) + k) % NREQ);
         if (!found && req[j]) begin
            found        = 1'b1;
            grant_oh[j]  = 1'b1;
            grant_idx    = j;
         end
      end
   end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Shares one APB master port among NREQ requesters with round-robin grant,
// wait-state absorption and an optional hung-slave timeout.
module apb_rr_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ-1:0]  req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]  req_done,
   output logic [DW-1:0]    rsp_rdata,
   output logic             rsp_err,
   output logic [AW-1:0]    PADDR,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [DW-1:0]    PWDATA,
   input  logic [DW-1:0]    PRDATA,
   input  logic             PREADY,
   input  logic             PSLVERR
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = tcnt_width(TIMEOUT);
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [IW-1:0]   grant_idx_q, grant_idx_d;
   logic [NREQ-1:0] grant_oh_q, grant_oh_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;
   logic            pwrite_q, pwrite_d;
   logic [DW-1:0]   pwdata_q, pwdata_d;
   logic [NREQ-1:0] req_done_q, req_done_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            rsp_err_q, rsp_err_d;

   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic [IW-1:0]   ptr_next;

   apb_rr_pick #(.NREQ(NREQ)) u_pick (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant_oh  (pick_oh),
      .grant_idx (pick_idx),
      .any       (pick_any)
   );

   assign ptr_next = (grant_idx_q == IW'(NREQ - 1)) ? '0 : grant_idx_q + IW'(1);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      tcnt_d      = tcnt_q;
      grant_idx_d = grant_idx_q;
      grant_oh_d  = grant_oh_q;
      paddr_d     = paddr_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      req_done_d  = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_idx_d = pick_idx;
               grant_oh_d  = pick_oh;
               paddr_d     = req_addr[int'(pick_idx)*AW +: AW];
               pwrite_d    = req_write[pick_idx];
               pwdata_d    = req_wdata[int'(pick_idx)*DW +: DW];
               psel_d      = 1'b1;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            tcnt_d    = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               req_done_d  = grant_oh_q;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               ptr_d       = ptr_next;
               state_d     = DONE;
            end else if (TIMEOUT != 0 && tcnt_q == TLIM) begin
               // Hung slave: complete the requester with an error so it never stalls.
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               req_done_d  = grant_oh_q;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               ptr_d       = ptr_next;
               state_d     = DONE;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         tcnt_q      <= '0;
         grant_idx_q <= '0;
         grant_oh_q  <= '0;
         paddr_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         req_done_q  <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         tcnt_q      <= tcnt_d;
         grant_idx_q <= grant_idx_d;
         grant_oh_q  <= grant_oh_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         req_done_q  <= req_done_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_done  = req_done_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PADDR     = paddr_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;

endmodule
